// File: rtl/cordic_pkg.sv
// Shared constants, types and the arctangent table for the CORDIC rotator.
// Build option: CORDIC_QUADRANT_EXT_EN enables the input quadrant fold in cordic_rotator.
package cordic_pkg;

  localparam int WIDTH       = 18;
  localparam int FRAC        = 16;
  localparam int GUARD       = 2;
  localparam int ITERATIONS  = 16;
  localparam int K_GAIN      = 39797;
  localparam int PI_Q16      = 205887;
  localparam int HALF_PI_Q16 = 102944;

  typedef logic signed [WIDTH-1:0] angle_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int ATAN_TAB [16] = '{
    51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
    256, 128, 64, 32, 16, 8, 4, 2
  };

  // atan(2^-idx) in Q2.16; indices past the table return zero
  function automatic int atan_q16(input int idx);
    if (idx >= 0 && idx < 16) begin
      return ATAN_TAB[idx];
    end
    return 0;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int IW = 21,
  parameter int CW = 5
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [IW-1:0] z,
  input  logic        [CW-1:0] i,
  input  logic signed [IW-1:0] atan,
  output logic signed [IW-1:0] x_next,
  output logic signed [IW-1:0] y_next,
  output logic signed [IW-1:0] z_next
);

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;
  logic                 pos;

  // rotate towards zero residual angle; direction follows the sign of z
  always_comb begin
    pos = ~z[IW-1];
    xs  = x >>> i;
    ys  = y >>> i;
    if (pos) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC producing cos/sin of a Q2.16 angle, one step per clock.
// Build option: CORDIC_QUADRANT_EXT_EN folds inputs beyond +-pi/2 so the full Q2.16 range is usable.
module cordic_rotator #(
  parameter int ITERATIONS = 16,
  parameter int WIDTH      = 18,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] target_angle,
  input  logic                    init,
  output logic signed [WIDTH-1:0] cosine,
  output logic signed [WIDTH-1:0] sine,
  output logic                    done
);

  import cordic_pkg::*;

  // one extra headroom bit above the guarded width keeps pi-sized z values safe
  localparam int IW  = WIDTH + GUARD + 1;
  localparam int CW  = $clog2(ITERATIONS + 1);
  localparam int RND = (GUARD > 0) ? (1 << (GUARD - 1)) : 0;

  typedef logic signed [IW-1:0] wide_t;

  localparam wide_t K_INIT = wide_t'(K_GAIN) <<< GUARD;
  localparam wide_t ONE    = wide_t'(1) <<< FRAC;
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS);

`ifdef CORDIC_QUADRANT_EXT_EN
  localparam wide_t PI_W      = wide_t'(PI_Q16);
  localparam wide_t HALF_PI_W = wide_t'(HALF_PI_Q16);
`endif

  state_t        state;
  state_t        state_next;
  wide_t         x;
  wide_t         y;
  wide_t         z;
  wide_t         xn;
  wide_t         yn;
  wide_t         zn;
  wide_t         angle_w;
  wide_t         z0;
  wide_t         tab;
  wide_t         xr;
  wide_t         yr;
  wide_t         cv;
  wide_t         sv;
  logic [CW-1:0] cnt;
  logic          negcos;
  logic          neg0;
  logic          load;
  logic          step;
  logic          finish;

  assign angle_w = wide_t'(target_angle);
  assign tab     = wide_t'(atan_q16(int'(cnt))) <<< GUARD;

  cordic_stage #(
    .IW(IW),
    .CW(CW)
  ) u_stage (
    .x     (x),
    .y     (y),
    .z     (z),
    .i     (cnt),
    .atan  (tab),
    .x_next(xn),
    .y_next(yn),
    .z_next(zn)
  );

  // starting angle, optionally folded into +-pi/2 with a cosine sign flip
  always_comb begin
    z0   = angle_w;
    neg0 = 1'b0;
`ifdef CORDIC_QUADRANT_EXT_EN
    if (angle_w > HALF_PI_W) begin
      z0   = PI_W - angle_w;
      neg0 = 1'b1;
    end else if (angle_w < -HALF_PI_W) begin
      z0   = -PI_W - angle_w;
      neg0 = 1'b1;
    end
`else
    z0   = angle_w;
    neg0 = 1'b0;
`endif
  end

  // round away the guard bits, apply the fold sign and clamp to +-1.0
  always_comb begin
    xr = (x + wide_t'(RND)) >>> GUARD;
    yr = (y + wide_t'(RND)) >>> GUARD;
    cv = negcos ? -xr : xr;
    sv = yr;
    if (cv > ONE) begin
      cv = ONE;
    end else if (cv < -ONE) begin
      cv = -ONE;
    end
    if (sv > ONE) begin
      sv = ONE;
    end else if (sv < -ONE) begin
      sv = -ONE;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state: init restarts from any state, RUN ends after the rounding edge
  always_comb begin
    state_next = state;
    if (init) begin
      state_next = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (cnt == LAST) state_next = S_DONE;
        default: state_next = state;
      endcase
    end
  end

  // control strobes and the done flag decoded from the state
  always_comb begin
    load   = init;
    step   = (state == S_RUN) && !init && (cnt != LAST);
    finish = (state == S_RUN) && !init && (cnt == LAST);
    done   = (state == S_DONE);
  end

  // datapath: load on init, iterate while running, publish results once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      cnt    <= '0;
      negcos <= 1'b0;
      cosine <= '0;
      sine   <= '0;
    end else if (load) begin
      x      <= K_INIT;
      y      <= '0;
      z      <= z0 <<< GUARD;
      cnt    <= '0;
      negcos <= neg0;
    end else if (step) begin
      x   <= xn;
      y   <= yn;
      z   <= zn;
      cnt <= cnt + 1'b1;
    end else if (finish) begin
      cosine <= WIDTH'(cv);
      sine   <= WIDTH'(sv);
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator against a real-valued cos/sin reference.
module tb_cordic_rotator;

  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  angle_t      target_angle;
  logic signed [17:0] cosine;
  logic signed [17:0] sine;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int prevCos;
  int prevSin;

  always #5 clk = ~clk;

  cordic_rotator dut (
    .clk         (clk),
    .rst         (rst),
    .target_angle(target_angle),
    .init        (init),
    .cosine      (cosine),
    .sine        (sine),
    .done        (done)
  );

  // one comparison with an absolute tolerance
  task automatic checkValue(input string tag, input int observed, input int expected, input int tol);
    int diff;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    compared++;
    assert ((diff <= tol) === 1'b1) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
    end
  endtask

  // single-cycle init pulse; remembers the outputs that must hold during RUN
  task automatic applyStimulus(input int angle);
    @(negedge clk);
    prevCos      = int'(cosine);
    prevSin      = int'(sine);
    target_angle = angle_t'(angle);
    init         = 1'b1;
    @(negedge clk);
    init         = 1'b0;
  endtask

  // waits for done, checks latency, output hold during RUN and the trig result
  task automatic checkOutput(input string tag, input int angle);
    int  n;
    int  ec;
    int  es;
    real r;
    bit  seen;
    checkValue({tag, ".done_drop"}, int'(done), 0, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 16) begin
        checkValue({tag, ".hold_cos"}, int'(cosine), prevCos, 0);
        checkValue({tag, ".hold_sin"}, int'(sine), prevSin, 0);
      end
      if (done) seen = 1'b1;
    end
    checkValue({tag, ".latency"}, n, 17, 0);
    r  = real'(angle) / 65536.0;
    ec = int'($cos(r) * 65536.0);
    es = int'($sin(r) * 65536.0);
    checkValue({tag, ".cos"}, int'(cosine), ec, 8);
    checkValue({tag, ".sin"}, int'(sine), es, 8);
  endtask

  initial begin
    rst          = 1'b1;
    init         = 1'b0;
    target_angle = '0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset.cos", int'(cosine), 0, 0);
    checkValue("reset.sin", int'(sine), 0, 0);
    checkValue("reset.done", int'(done), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0);
    checkOutput("zero", 0);
    applyStimulus(16384);
    checkOutput("pos_quarter", 16384);
    applyStimulus(-16384);
    checkOutput("neg_quarter", -16384);
    applyStimulus(98304);
    checkOutput("one_and_half", 98304);
    applyStimulus(102944);
    checkOutput("plus_half_pi", 102944);
    applyStimulus(-102944);
    checkOutput("minus_half_pi", -102944);

    // re-pulse mid-RUN: the first computation is abandoned
    applyStimulus(50000);
    repeat (5) @(posedge clk);
    applyStimulus(-70000);
    checkOutput("repulse", -70000);

    // init held high: every edge reloads, the last sampled angle wins
    @(negedge clk);
    prevCos      = int'(cosine);
    prevSin      = int'(sine);
    init         = 1'b1;
    target_angle = angle_t'(20000);
    @(negedge clk);
    target_angle = angle_t'(-40000);
    @(negedge clk);
    target_angle = angle_t'(60000);
    @(negedge clk);
    init = 1'b0;
    checkOutput("held_init", 60000);

    // asynchronous reset in the middle of a run
    applyStimulus(32768);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkValue("async_rst.cos", int'(cosine), 0, 0);
    checkValue("async_rst.sin", int'(sine), 0, 0);
    checkValue("async_rst.done", int'(done), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32768);
    checkOutput("after_rst", 32768);

    for (int k = 0; k < 10; k++) begin
      int a;
      a = int'($urandom_range(205888)) - 102944;
      applyStimulus(a);
      checkOutput("random", a);
    end

`ifdef CORDIC_QUADRANT_EXT_EN
    applyStimulus(120000);
    checkOutput("fold_pos", 120000);
    applyStimulus(-120000);
    checkOutput("fold_neg", -120000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
